// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port DataMemory arbiter: FSM encoding, port IDs
// and default geometry.
package mem_arb_pkg;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] BUSY    = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic PORT_I = 1'b0;
   localparam logic PORT_D = 1'b1;

   localparam int DEF_BLOCK_BITS = 256;
   localparam int DEF_ADDR_WIDTH = 32;

   // After a completion, the losing side gets priority on the next tie.
   function automatic logic other_port(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational round-robin selector for two requesters: bit 0 = port I,
// bit 1 = port D; prio names the port that wins a tie.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       prio,
   output logic       gnt_valid,
   output logic       gnt_id
);

   // NOTE: every output of an always_comb gets a default first, so no path
   // can leave it unassigned and infer a latch.
   always_comb begin
      gnt_valid = |req;
      gnt_id    = prio;
      case (req)
         2'b01:   gnt_id = PORT_I;
         2'b10:   gnt_id = PORT_D;
         default: gnt_id = prio;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one block-wide DataMemory port between the
// I-cache and D-cache controllers. Optional watchdog: define ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int pBlockBits = DEF_BLOCK_BITS,
   parameter int pAddrWidth = DEF_ADDR_WIDTH,
   parameter int pTimeout   = 64
)
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,

   input  logic                  i_req_i,
   input  logic [pAddrWidth-1:0] i_addr_i,
   input  logic                  i_write_ctrl_i,
   input  logic [pBlockBits-1:0] i_write_data_i,
   output logic                  i_ack_o,
   output logic [pBlockBits-1:0] i_read_data_o,

   input  logic                  d_req_i,
   input  logic [pAddrWidth-1:0] d_addr_i,
   input  logic                  d_write_ctrl_i,
   input  logic [pBlockBits-1:0] d_write_data_i,
   output logic                  d_ack_o,
   output logic [pBlockBits-1:0] d_read_data_o,

   output logic                  mem_enable_o,
   output logic [pAddrWidth-1:0] mem_addr_o,
   output logic                  mem_write_ctrl_o,
   output logic [pBlockBits-1:0] mem_write_data_o,
   input  logic                  mem_ack_i,
   input  logic [pBlockBits-1:0] mem_read_data_i,

`ifdef ARB_TIMEOUT_EN
   output logic                  err_o,
`endif
   output logic                  busy_o,
   output logic                  grant_o
);

   logic [1:0] state;
   logic       prio;
   logic       pick_valid;
   logic       pick_id;
   logic       wd_expire;

   rr_pick2 u_pick (
      .req       ({d_req_i, i_req_i}),
      .prio      (prio),
      .gnt_valid (pick_valid),
      .gnt_id    (pick_id)
   );

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] WD_LAST = 8'(pTimeout - 1);

   logic [7:0] wd_cnt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wd_cnt <= '0;
      end else if (state == IDLE) begin
         wd_cnt <= '0;
      end else if (state == BUSY) begin
         wd_cnt <= wd_cnt + 8'd1;
      end
   end

   // Fires on the pTimeout-th BUSY edge without a memory ack.
   assign wd_expire = (wd_cnt == WD_LAST);
`else
   assign wd_expire = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         // NOTE: the block-wide read-data registers are reset too; they are
         // visible outputs, not an internal memory array.
         state            <= IDLE;
         prio             <= PORT_I;
         mem_enable_o     <= 1'b0;
         mem_addr_o       <= '0;
         mem_write_ctrl_o <= 1'b0;
         mem_write_data_o <= '0;
         i_ack_o          <= 1'b0;
         d_ack_o          <= 1'b0;
         i_read_data_o    <= '0;
         d_read_data_o    <= '0;
         busy_o           <= 1'b0;
         grant_o          <= PORT_I;
`ifdef ARB_TIMEOUT_EN
         err_o            <= 1'b0;
`endif
      end else begin
         i_ack_o <= 1'b0;
         d_ack_o <= 1'b0;

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  mem_addr_o       <= (pick_id == PORT_D) ? d_addr_i       : i_addr_i;
                  mem_write_ctrl_o <= (pick_id == PORT_D) ? d_write_ctrl_i : i_write_ctrl_i;
                  mem_write_data_o <= (pick_id == PORT_D) ? d_write_data_i : i_write_data_i;
                  mem_enable_o     <= 1'b1;
                  busy_o           <= 1'b1;
                  grant_o          <= pick_id;
                  state            <= BUSY;
               end
            end

            BUSY: begin
               if (mem_ack_i || wd_expire) begin
                  mem_enable_o <= 1'b0;
                  prio         <= other_port(grant_o);
                  state        <= RELEASE;
                  if (grant_o == PORT_D) d_ack_o <= 1'b1;
                  else                   i_ack_o <= 1'b1;

                  if (!mem_ack_i) begin
                     // Watchdog completion: hand back a zero block.
                     if (grant_o == PORT_D) d_read_data_o <= '0;
                     else                   i_read_data_o <= '0;
`ifdef ARB_TIMEOUT_EN
                     err_o <= 1'b1;
`endif
                  end else if (!mem_write_ctrl_o) begin
                     if (grant_o == PORT_D) d_read_data_o <= mem_read_data_i;
                     else                   i_read_data_o <= mem_read_data_i;
                  end
               end
            end

            RELEASE: begin
               // One idle bubble so the acked requester can drop req before
               // the next pick.
               busy_o <= 1'b0;
               state  <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: cache drivers, a latency-programmable
// memory responder and a monitor comparing grants, mem_* fields and acks.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int BB = 256;
   localparam int AW = 32;
`ifdef ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 64;
`endif

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          i_req_i = 1'b0, d_req_i = 1'b0;
   logic [AW-1:0] i_addr_i = '0, d_addr_i = '0;
   logic          i_write_ctrl_i = 1'b0, d_write_ctrl_i = 1'b0;
   logic [BB-1:0] i_write_data_i = '0, d_write_data_i = '0;
   logic          i_ack_o, d_ack_o;
   logic [BB-1:0] i_read_data_o, d_read_data_o;
   logic          mem_enable_o, mem_write_ctrl_o;
   logic [AW-1:0] mem_addr_o;
   logic [BB-1:0] mem_write_data_o;
   logic          mem_ack_i = 1'b0;
   logic [BB-1:0] mem_read_data_i = '0;
   logic          busy_o, grant_o;
`ifdef ARB_TIMEOUT_EN
   logic          err_o;
`endif

   mem_port_arbiter #(.pBlockBits(BB), .pAddrWidth(AW), .pTimeout(TO)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_write_ctrl_i(i_write_ctrl_i),
      .i_write_data_i(i_write_data_i), .i_ack_o(i_ack_o), .i_read_data_o(i_read_data_o),
      .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_write_ctrl_i(d_write_ctrl_i),
      .d_write_data_i(d_write_data_i), .d_ack_o(d_ack_o), .d_read_data_o(d_read_data_o),
      .mem_enable_o(mem_enable_o), .mem_addr_o(mem_addr_o), .mem_write_ctrl_o(mem_write_ctrl_o),
      .mem_write_data_o(mem_write_data_o), .mem_ack_i(mem_ack_i), .mem_read_data_i(mem_read_data_i),
`ifdef ARB_TIMEOUT_EN
      .err_o(err_o),
`endif
      .busy_o(busy_o), .grant_o(grant_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic          port;
      logic [AW-1:0] addr;
      logic          wr;
      logic [BB-1:0] wdata;
      logic [BB-1:0] rdata;
   } exp_t;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [BB-1:0] wdata;
   } cmd_t;

   exp_t          exp_q[$];
   cmd_t          i_q[$], d_q[$];
   logic          grant_log[$];
   logic [BB-1:0] mem_img [logic [AW-1:0]];

   int checks = 0, errors = 0;
   int cyc = 0;
   int mem_lat = 3;
   bit mem_mute = 1'b0;
   bit spur_req = 1'b0;
   int rise_cnt = 0, rise_cyc = 0, last_ack_cyc = -100, last_lat = 0, ack_total = 0;
   logic [BB-1:0] last_i_rd = '0, last_d_rd = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [BB-1:0] img_read(input logic [AW-1:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return {8{a ^ 32'h5A5A_0F0F}};
   endfunction

   // Memory responder: ack mem_lat cycles after enable unless muted.
   initial begin : responder
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (spur_req) begin
            mem_ack_i = 1'b1;
            mem_read_data_i = {8{32'hBAD0_BAD0}};
            spur_req = 1'b0;
         end else if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
         end else if (mem_enable_o && !mem_mute) begin
            cnt++;
            if (cnt >= mem_lat) begin
               mem_ack_i = 1'b1;
               if (mem_write_ctrl_o) begin
                  mem_img[mem_addr_o] = mem_write_data_o;
                  mem_read_data_i = {8{32'hDEAD_BEEF}};
               end else begin
                  mem_read_data_i = img_read(mem_addr_o);
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Cache-side drivers: hold req until ack, then load the next queued command.
   initial begin : driver
      cmd_t c;
      forever begin
         @(negedge clk_i);
         if (i_ack_o) i_req_i = 1'b0;
         if (d_ack_o) d_req_i = 1'b0;
         if (!i_req_i && i_q.size() > 0) begin
            c = i_q.pop_front();
            i_req_i = 1'b1; i_addr_i = c.addr; i_write_ctrl_i = c.wr; i_write_data_i = c.wdata;
         end
         if (!d_req_i && d_q.size() > 0) begin
            c = d_q.pop_front();
            d_req_i = 1'b1; d_addr_i = c.addr; d_write_ctrl_i = c.wr; d_write_data_i = c.wdata;
         end
      end
   end

   initial begin : monitor
      logic          pe, pia, pda, port;
      logic [BB-1:0] act, want;
      exp_t          e;
      pe = 1'b0; pia = 1'b0; pda = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_n_i) begin
            pe = 1'b0; pia = 1'b0; pda = 1'b0;
         end else begin
            if (mem_enable_o && !pe) begin
               rise_cnt++;
               rise_cyc = cyc;
               checks++;
               if (cyc - last_ack_cyc < 2) begin
                  errors++;
                  $display("FAIL grant_gap: got %0d cycles after ack, want >= 2", cyc - last_ack_cyc);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL enable_unexpected: mem_enable_o rose with nothing expected");
               end else begin
                  e = exp_q[0];
                  checks++;
                  if (grant_o !== e.port) begin
                     errors++;
                     $display("FAIL grant_at_enable: got %b want %b", grant_o, e.port);
                  end
                  checks++;
                  if (mem_addr_o !== e.addr || mem_write_ctrl_o !== e.wr) begin
                     errors++;
                     $display("FAIL mem_cmd: got addr %h wr %b want addr %h wr %b",
                              mem_addr_o, mem_write_ctrl_o, e.addr, e.wr);
                  end
                  if (e.wr) begin
                     checks++;
                     if (mem_write_data_o !== e.wdata) begin
                        errors++;
                        $display("FAIL mem_wdata: got %h want %h", mem_write_data_o, e.wdata);
                     end
                  end
               end
            end

            if (i_ack_o || d_ack_o) begin
               ack_total++;
               port = d_ack_o;
               checks++;
               if (i_ack_o && d_ack_o) begin
                  errors++;
                  $display("FAIL both_ack: got i=%b d=%b want one", i_ack_o, d_ack_o);
               end
               checks++;
               if ((i_ack_o && pia) || (d_ack_o && pda)) begin
                  errors++;
                  $display("FAIL ack_width: got ack high 2 cycles want 1");
               end
               checks++;
               if (busy_o !== 1'b1) begin
                  errors++;
                  $display("FAIL busy_at_ack: got %b want 1", busy_o);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL ack_unexpected: got ack port %b want none", port);
               end else begin
                  e = exp_q.pop_front();
                  checks++;
                  if (port !== e.port || grant_o !== e.port) begin
                     errors++;
                     $display("FAIL ack_port: got port %b grant %b want %b", port, grant_o, e.port);
                  end
                  act  = port ? d_read_data_o : i_read_data_o;
                  want = e.wr ? (port ? last_d_rd : last_i_rd) : e.rdata;
                  if (!e.wr) begin
                     if (port) last_d_rd = e.rdata;
                     else      last_i_rd = e.rdata;
                  end
                  checks++;
                  if (act !== want) begin
                     errors++;
                     $display("FAIL read_data: got %h want %h", act, want);
                  end
               end
               last_lat = cyc - rise_cyc;
               last_ack_cyc = cyc;
               grant_log.push_back(port);
            end
            pe = mem_enable_o; pia = i_ack_o; pda = d_ack_o;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   task automatic wait_drain(output bit ok);
      int n;
      n = 0;
      while ((exp_q.size() > 0 || i_req_i || d_req_i || busy_o) && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      ok = (n < 400);
      repeat (2) @(negedge clk_i);
   endtask

   task automatic push(input logic port, input logic wr, input logic [AW-1:0] addr,
                       input logic [BB-1:0] wdata, input logic [BB-1:0] rdata);
      exp_t e;
      cmd_t c;
      e.port = port; e.addr = addr; e.wr = wr; e.wdata = wdata; e.rdata = rdata;
      c.wr = wr; c.addr = addr; c.wdata = wdata;
      exp_q.push_back(e);
      if (port == PORT_D) d_q.push_back(c);
      else                i_q.push_back(c);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_n_i = 1'b0;
      repeat (2) @(negedge clk_i);
      last_i_rd = '0; last_d_rd = '0;
      rst_n_i = 1'b1;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_i);
      checks++;
      if ({mem_enable_o, mem_write_ctrl_o, i_ack_o, d_ack_o, busy_o, grant_o} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {mem_enable_o, mem_write_ctrl_o, i_ack_o, d_ack_o, busy_o, grant_o});
      end
      checks++;
      if (mem_addr_o !== '0 || mem_write_data_o !== '0) begin
         errors++;
         $display("FAIL reset_mem: got addr %h wdata %h want 0", mem_addr_o, mem_write_data_o);
      end
      checks++;
      if (i_read_data_o !== '0 || d_read_data_o !== '0) begin
         errors++;
         $display("FAIL reset_rdata: got i %h d %h want 0", i_read_data_o, d_read_data_o);
      end
      rst_n_i = 1'b1;
   endtask

   task automatic test_single_read();
      bit ok;
      int r0;
      r0 = rise_cnt;
      mem_lat = 3;
      mem_img[32'h40] = {32{8'hA5}};
      push(PORT_I, 1'b0, 32'h40, '0, {32{8'hA5}});
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL single_read_done: got timeout want completion"); end
      checks++;
      if (last_lat != 3) begin errors++; $display("FAIL single_read_latency: got %0d want 3", last_lat); end
      checks++;
      if (rise_cnt - r0 != 1) begin errors++; $display("FAIL single_read_enables: got %0d want 1", rise_cnt - r0); end
      checks++;
      if (i_read_data_o !== {32{8'hA5}}) begin
         errors++;
         $display("FAIL single_read_hold: got %h want a5..a5", i_read_data_o);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      int r0;
      do_reset();
      grant_log.delete();
      r0 = rise_cnt;
      push(PORT_I, 1'b0, 32'h1000, '0, img_read(32'h1000));
      push(PORT_D, 1'b0, 32'h2000, '0, img_read(32'h2000));
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL simul_done: got timeout want completion"); end
      checks++;
      if (grant_log.size() != 2 || grant_log[0] !== PORT_I || grant_log[1] !== PORT_D) begin
         errors++;
         $display("FAIL simul_order: got %0d grants first %b want I then D", grant_log.size(),
                  grant_log.size() > 0 ? grant_log[0] : 1'bx);
      end
      checks++;
      if (rise_cnt - r0 != 2) begin errors++; $display("FAIL simul_enables: got %0d want 2", rise_cnt - r0); end
   endtask

   task automatic test_contention();
      bit ok;
      int r0;
      logic [AW-1:0] a;
      grant_log.delete();
      r0 = rise_cnt;
      mem_lat = 2;
      for (int k = 0; k < 3; k++) begin
         a = 32'h3000 + 32'(k * 32);
         push(PORT_I, 1'b0, a, '0, img_read(a));
         a = 32'h4000 + 32'(k * 32);
         push(PORT_D, 1'b0, a, '0, img_read(a));
      end
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL contention_done: got timeout want completion"); end
      checks++;
      if (rise_cnt - r0 != 6) begin errors++; $display("FAIL contention_enables: got %0d want 6", rise_cnt - r0); end
      for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
         checks++;
         if (grant_log[k] !== logic'(k % 2)) begin
            errors++;
            $display("FAIL contention_order[%0d]: got %b want %b", k, grant_log[k], logic'(k % 2));
         end
      end
      mem_lat = 3;
   endtask

   task automatic test_write_back();
      bit ok;
      logic [BB-1:0] prior, wd;
      wd = {8{32'h1234_5678}};
      prior = d_read_data_o;
      push(PORT_D, 1'b1, 32'h80, wd, '0);
      wait_drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL write_done: got timeout want completion"); end
      checks++;
      if (d_read_data_o !== prior) begin
         errors++;
         $display("FAIL write_rdata_kept: got %h want %h", d_read_data_o, prior);
      end
      push(PORT_I, 1'b0, 32'h80, '0, wd);
      wait_drain(ok);
      checks++;
      if (i_read_data_o !== wd) begin
         errors++;
         $display("FAIL write_readback: got %h want %h", i_read_data_o, wd);
      end
   endtask

   task automatic test_spurious_ack();
      int a0;
      a0 = ack_total;
      @(negedge clk_i);
      spur_req = 1'b1;
      repeat (4) @(negedge clk_i);
      checks++;
      if (ack_total != a0 || busy_o !== 1'b0 || mem_enable_o !== 1'b0) begin
         errors++;
         $display("FAIL spurious_ack: got acks %0d busy %b en %b want 0 0 0",
                  ack_total - a0, busy_o, mem_enable_o);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n, a0;
      mem_mute = 1'b1;
      push(PORT_I, 1'b0, 32'h200, '0, img_read(32'h200));
      n = 0;
      while (!busy_o && n < 20) begin @(negedge clk_i); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL mid_reset_busy: got busy 0 want 1"); end
      repeat (2) @(negedge clk_i);
      a0 = ack_total;
      rst_n_i = 1'b0;
      i_q.delete(); d_q.delete(); exp_q.delete();
      i_req_i = 1'b0; d_req_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (mem_enable_o !== 1'b0 || busy_o !== 1'b0 || i_ack_o !== 1'b0 || d_ack_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_state: got en %b busy %b ack %b%b want 0 0 00",
                  mem_enable_o, busy_o, i_ack_o, d_ack_o);
      end
      checks++;
      if (i_read_data_o !== '0) begin
         errors++;
         $display("FAIL mid_reset_rdata: got %h want 0", i_read_data_o);
      end
      last_i_rd = '0; last_d_rd = '0;
      rst_n_i = 1'b1;
      mem_mute = 1'b0;
      repeat (3) @(negedge clk_i);
      checks++;
      if (ack_total != a0) begin errors++; $display("FAIL mid_reset_noack: got %0d acks want 0", ack_total - a0); end
      push(PORT_D, 1'b0, 32'h300, '0, img_read(32'h300));
      wait_drain(ok);
      checks++;
      if (!ok || ack_total != a0 + 1) begin
         errors++;
         $display("FAIL post_reset_serve: got %0d acks want 1", ack_total - a0);
      end
   endtask

`ifdef ARB_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL err_initial: got %b want 0", err_o); end
      mem_mute = 1'b1;
      push(PORT_I, 1'b0, 32'h500, '0, '0);
      wait_drain(ok);
      mem_mute = 1'b0;
      checks++;
      if (!ok) begin errors++; $display("FAIL timeout_done: got no ack want watchdog ack"); end
      checks++;
      if (last_lat != TO) begin errors++; $display("FAIL timeout_latency: got %0d want %0d", last_lat, TO); end
      checks++;
      if (err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", err_o); end
      push(PORT_D, 1'b0, 32'h600, '0, img_read(32'h600));
      wait_drain(ok);
      checks++;
      if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err_o); end
      do_reset();
      @(negedge clk_i);
      checks++;
      if (err_o !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", err_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_contention();
      test_write_back();
      test_spurious_ack();
      test_reset_mid();
`ifdef ARB_TIMEOUT_EN
      test_timeout();
`endif
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect: got %0d pending want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
